id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL expose parameter REG_AW, default 5, register-index width.
REQ-002 SHALL expose ports: clk  in  1  pipeline clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL expose: id_valid  in  1  ID holds a real instruction; id_rs1, id_rs2  in  REG_AW  source indices; id_use_rs1, id_use_rs2  in  1  source read.
REQ-004 SHALL expose: id_rd  in  REG_AW  destination; id_reg_write  in  1  writes rd; id_mem_read  in  1  load; id_is_branch  in  1  branch compared in ID.
REQ-005 SHALL expose: branch_taken  in  1  ID compare resolved taken; mem_busy  in  1  data memory not ready, freezes pipeline.
REQ-006 SHALL expose: rs1_fwd_id, rs2_fwd_id  out  2  ID operand select (`FROM_REG`/`FROM_MEM`); stall_if, stall_id  out  1  hold PC and IF/ID; bubble_ex  out  1  insert NOP into ID/EX; flush_id  out  1  squash IF/ID.

Function
REQ-007 SHALL track EX-stage and MEM-stage {rd, reg_write, mem_read, valid} in internal shadow registers, advancing ID->EX->MEM on every cycle with mem_busy=0.
REQ-008 SHALL enter a bubble (valid=0) into the EX shadow whenever bubble_ex=1.
REQ-009 SHALL treat a source as hazardous only when used, id_valid=1, index nonzero, and it matches a valid writing stage; x0 never hazards.
REQ-010 SHALL drive rsN_fwd_id=`FROM_MEM` when rsN matches a MEM-stage non-load writer and no EX-stage match applies; else `FROM_REG`; EX-stage match takes priority.
REQ-011 SHALL compute required stall count: branch vs EX ALU writer = 1; branch vs EX load = 2; branch vs MEM load = 1; non-branch vs EX load = 1; otherwise 0; maximum over both sources.
REQ-012 SHALL use FSM RUN, STALL1, STALL2: RUN->STALL2 on count 2, RUN->STALL1 on count 1, STALL2->STALL1, STALL1->RUN, each transition only when mem_busy=0.
REQ-013 SHALL assert stall_if=stall_id=bubble_ex=1 in the cycle a nonzero count is detected and throughout STALL states until the final stall cycle completes.
REQ-014 SHALL re-evaluate hazards combinationally from shadow state each cycle so the FSM exits no earlier than dependences clear.
REQ-015 SHALL assert stall_if=stall_id=1, bubble_ex=0 while mem_busy=1, holding FSM state and shadows.
REQ-016 SHALL assert flush_id=1 for one cycle when branch_taken=1 and no stall or mem_busy is active; branch_taken during stall SHALL be ignored.
REQ-017 SHALL give mem_busy priority over hazard stall, hazard stall priority over flush.

Reset
REQ-018 SHALL on rst_n=0 asynchronously set FSM=RUN, all shadow valids=0, all outputs 0, fwd selects `FROM_REG`.
REQ-019 SHALL on reset mid-stall abandon the stall; first post-reset cycle behaves as RUN with empty shadows.

Configuration
REQ-020 SHALL with HAZARD_PERF_EN defined add outputs stall_cnt (32) and flush_cnt (32), saturating counters of hazard-stall cycles and flush_id pulses, reset to 0.
REQ-021 SHALL without HAZARD_PERF_EN omit those ports and counters; all other behaviour identical.

Structure
REQ-022 SHALL take `FROM_REG`/`FROM_MEM` and FSM state encodings from the shared defines file; no local redefinition.
REQ-023 SHALL instantiate one sub-module, hazard_detect, combinationally producing per-source match flags and stall count from ID fields and shadows.

Verification
REQ-024 SHALL cover: add x5 then beq x5,x0 next -> 1 stall cycle (stall_if=1, bubble_ex=1), then rs1_fwd_id=`FROM_MEM`.
REQ-025 SHALL cover: lw x6 then beq x6,x1 next -> 2 stall cycles, FSM RUN->STALL2->STALL1->RUN.
REQ-026 SHALL cover: lw x7 then add x8,x7,x7 -> exactly 1 stall; add x0 writer then beq x0 -> 0 stalls.
REQ-027 SHALL cover: mem_busy=1 for 3 cycles during STALL2 -> stall held, bubble_ex=0, FSM stays STALL2, resumes after.
REQ-028 SHALL cover: branch_taken=1 with no hazard -> flush_id pulse 1 cycle; rst_n low in STALL1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: operand-select
// encodings, FSM state encoding and small helpers used by the detector.
package id_hazard_ctrl_pkg;

    // ID operand select: read the register file, or take the MEM-stage result
    localparam logic [1:0] FROM_REG = 2'b00;
    localparam logic [1:0] FROM_MEM = 2'b01;

    // Stall sequencer states
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL1 = 2'b01,
        STALL2 = 2'b10
    } hazard_state_t;

    // Stall cycles one source needs. A branch compares in ID, so it must wait
    // for an ALU result to reach MEM (1) and for a load to leave MEM (2 from EX,
    // 1 from MEM). Other instructions only wait for a load sitting in EX.
    function automatic logic [1:0] src_stall(input logic is_branch,
                                             input logic ex_match,
                                             input logic ex_load,
                                             input logic mem_match,
                                             input logic mem_load);
        logic [1:0] cnt;
        cnt = 2'd0;
        if (ex_match) begin
            if (is_branch) cnt = ex_load ? 2'd2 : 2'd1;
            else           cnt = ex_load ? 2'd1 : 2'd0;
        end else if (mem_match && mem_load && is_branch) begin
            cnt = 2'd1;
        end
        return cnt;
    endfunction

    function automatic logic [1:0] max_count(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_hazard_detect.sv
// Combinational hazard detector: compares the ID sources against the EX and
// MEM shadow entries and produces per-source match flags and the stall count.
module hazard_detect
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic              mem_valid,
    output logic              rs1_ex_match,
    output logic              rs1_mem_match,
    output logic              rs2_ex_match,
    output logic              rs2_mem_match,
    output logic [1:0]        stall_count
);

    logic ex_writer;
    logic mem_writer;
    logic rs1_live;
    logic rs2_live;

    // A source only matters when it is really read and is not x0
    always_comb begin
        ex_writer     = ex_valid & ex_reg_write;
        mem_writer    = mem_valid & mem_reg_write;
        rs1_live      = id_valid & id_use_rs1 & (id_rs1 != '0);
        rs2_live      = id_valid & id_use_rs2 & (id_rs2 != '0);
        rs1_ex_match  = rs1_live & ex_writer  & (ex_rd  == id_rs1);
        rs1_mem_match = rs1_live & mem_writer & (mem_rd == id_rs1);
        rs2_ex_match  = rs2_live & ex_writer  & (ex_rd  == id_rs2);
        rs2_mem_match = rs2_live & mem_writer & (mem_rd == id_rs2);
        stall_count   = max_count(
            src_stall(id_is_branch, rs1_ex_match, ex_mem_read, rs1_mem_match, mem_mem_read),
            src_stall(id_is_branch, rs2_ex_match, ex_mem_read, rs2_mem_match, mem_mem_read));
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: tracks EX/MEM destinations in shadow registers,
// selects ID operand forwarding, sequences load/branch stalls and squashes
// IF/ID on taken branches. Defining HAZARD_PERF_EN adds saturating counters
// of hazard-stall cycles (stall_cnt) and flush pulses (flush_cnt).
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_is_branch,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic [1:0]        rs1_fwd_id,
    output logic [1:0]        rs2_fwd_id,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_id
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    hazard_state_t     state;
    hazard_state_t     state_next;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_valid;
    logic              rs1_ex_match;
    logic              rs1_mem_match;
    logic              rs2_ex_match;
    logic              rs2_mem_match;
    logic [1:0]        stall_count;
    logic              hazard_stall;
    logic              flush_raw;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_is_branch  (id_is_branch),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_valid      (ex_valid),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_valid     (mem_valid),
        .rs1_ex_match  (rs1_ex_match),
        .rs1_mem_match (rs1_mem_match),
        .rs2_ex_match  (rs2_ex_match),
        .rs2_mem_match (rs2_mem_match),
        .stall_count   (stall_count)
    );

    // Shadow pipeline: ID->EX->MEM unless memory freezes; stalls inject a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_valid      <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_valid     <= 1'b0;
        end else if (!mem_busy) begin
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            mem_valid     <= ex_valid;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_valid      <= id_valid & ~hazard_stall;
        end
    end

    // Stall sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // Next state and hazard stall; the live count keeps the stall up until the
    // dependence really clears, STALL2 always covers the middle cycle
    always_comb begin
        state_next   = state;
        hazard_stall = (stall_count != 2'd0) || (state == STALL2);
        if (!mem_busy) begin
            case (state)
                STALL2:  state_next = STALL1;
                default: begin
                    if (stall_count == 2'd2)      state_next = STALL2;
                    else if (stall_count == 2'd1) state_next = STALL1;
                    else                          state_next = RUN;
                end
            endcase
        end
        flush_raw = branch_taken & ~mem_busy & ~hazard_stall;
    end

    // Pipeline control outputs: memory freeze beats hazard stall beats flush,
    // and everything reads as idle while reset is held
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        bubble_ex  = 1'b0;
        flush_id   = 1'b0;
        rs1_fwd_id = FROM_REG;
        rs2_fwd_id = FROM_REG;
        if (rst_n) begin
            stall_if  = mem_busy | hazard_stall;
            stall_id  = mem_busy | hazard_stall;
            bubble_ex = ~mem_busy & hazard_stall;
            flush_id  = flush_raw;
            if (rs1_mem_match && !rs1_ex_match && !mem_mem_read) rs1_fwd_id = FROM_MEM;
            if (rs2_mem_match && !rs2_ex_match && !mem_mem_read) rs2_fwd_id = FROM_MEM;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counters of hazard-stall cycles and flush pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!mem_busy && hazard_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (flush_raw && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl. Each scenario task drives
// an instruction sequence and compares the control outputs against
// hand-derived values; ctl packs {stall_if, stall_id, bubble_ex, flush_id}.
module tb_id_hazard_ctrl;
    import id_hazard_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_is_branch;
    logic       branch_taken;
    logic       mem_busy;
    logic [1:0] rs1_fwd_id;
    logic [1:0] rs2_fwd_id;
    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic       flush_id;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif
    logic [3:0] ctl;
    logic [3:0] fwd;
    int checks;
    int errors;

    assign ctl = {stall_if, stall_id, bubble_ex, flush_id};
    assign fwd = {rs1_fwd_id, rs2_fwd_id};

    id_hazard_ctrl #(.REG_AW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_is_branch (id_is_branch),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .rs1_fwd_id   (rs1_fwd_id),
        .rs2_fwd_id   (rs2_fwd_id),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .flush_id     (flush_id)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // 10 ns pipeline clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_branch = br;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        branch_taken = 0;
        mem_busy = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_busy = 1'b1;
        branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl, 4'b0000); end
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL reset_fwd: got %b want %b", fwd, 4'b0000); end
        checks++; if (dut.state !== RUN) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", dut.state, RUN); end
        tick();
        rst_n = 1'b1;
        mem_busy = 1'b0;
        branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL post_reset_ctl: got %b want %b", ctl, 4'b0000); end
    endtask

    task automatic test_alu_branch();
        drain();
        set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);                 // add x5,x1,x2
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL alu_br_issue: got %b want %b", ctl, 4'b0000); end
        tick();
        set_id(1, 5, 0, 1, 1, 0, 0, 0, 1);                 // beq x5,x0
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("[TB] FAIL alu_br_stall: got %b want %b", ctl, 4'b1110); end
        tick();
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL alu_br_release: got %b want %b", ctl, 4'b0000); end
        checks++; if (fwd !== {FROM_MEM, FROM_REG}) begin errors++; $display("[TB] FAIL alu_br_fwd: got %b want %b", fwd, {FROM_MEM, FROM_REG}); end
        checks++; if (dut.state !== STALL1) begin errors++; $display("[TB] FAIL alu_br_state: got %0d want %0d", dut.state, STALL1); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (dut.state !== RUN) begin errors++; $display("[TB] FAIL alu_br_run: got %0d want %0d", dut.state, RUN); end
    endtask

    task automatic test_load_branch();
        drain();
        set_id(1, 1, 0, 1, 0, 6, 1, 1, 0);                 // lw x6,0(x1)
        tick();
        set_id(1, 6, 1, 1, 1, 0, 0, 0, 1);                 // beq x6,x1
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("[TB] FAIL ld_br_stall1: got %b want %b", ctl, 4'b1110); end
        tick();
        branch_taken = 1'b1;                               // must be ignored while stalled
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("[TB] FAIL ld_br_stall2: got %b want %b", ctl, 4'b1110); end
        checks++; if (dut.state !== STALL2) begin errors++; $display("[TB] FAIL ld_br_state2: got %0d want %0d", dut.state, STALL2); end
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL ld_br_fwd: got %b want %b", fwd, 4'b0000); end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL ld_br_release: got %b want %b", ctl, 4'b0000); end
        checks++; if (dut.state !== STALL1) begin errors++; $display("[TB] FAIL ld_br_state1: got %0d want %0d", dut.state, STALL1); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (dut.state !== RUN) begin errors++; $display("[TB] FAIL ld_br_run: got %0d want %0d", dut.state, RUN); end
    endtask

    task automatic test_load_use_x0();
        drain();
        set_id(1, 2, 0, 1, 0, 7, 1, 1, 0);                 // lw x7,0(x2)
        tick();
        set_id(1, 7, 7, 1, 1, 8, 1, 0, 0);                 // add x8,x7,x7
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("[TB] FAIL ld_use_stall: got %b want %b", ctl, 4'b1110); end
        tick();
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL ld_use_once: got %b want %b", ctl, 4'b0000); end
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL ld_use_fwd: got %b want %b", fwd, 4'b0000); end
        tick();
        set_id(1, 1, 2, 1, 1, 0, 1, 0, 0);                 // add x0,x1,x2
        tick();
        set_id(1, 0, 0, 1, 1, 0, 0, 0, 1);                 // beq x0,x0
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL x0_no_stall: got %b want %b", ctl, 4'b0000); end
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL x0_fwd: got %b want %b", fwd, 4'b0000); end
    endtask

    task automatic test_fwd_priority();
        drain();
        set_id(1, 1, 2, 1, 1, 9, 1, 0, 0);                 // add x9
        tick();
        tick();                                            // second add x9
        set_id(1, 1, 9, 1, 1, 3, 1, 0, 0);                 // add x3,x1,x9
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL prio_ctl: got %b want %b", ctl, 4'b0000); end
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL prio_ex_wins: got %b want %b", fwd, 4'b0000); end
        tick();
        set_id(1, 9, 2, 1, 1, 4, 1, 0, 0);                 // sub x4,x9,x2
        #1;
        checks++; if (fwd !== {FROM_MEM, FROM_REG}) begin errors++; $display("[TB] FAIL fwd_mem_rs1: got %b want %b", fwd, {FROM_MEM, FROM_REG}); end
        tick();
        set_id(1, 2, 3, 0, 1, 0, 0, 0, 0);                 // x3 now in MEM, read via rs2
        #1;
        checks++; if (fwd !== {FROM_REG, FROM_MEM}) begin errors++; $display("[TB] FAIL fwd_mem_rs2: got %b want %b", fwd, {FROM_REG, FROM_MEM}); end
        set_id(1, 2, 3, 0, 0, 0, 0, 0, 0);                 // same indices, rs2 unused
        #1;
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL fwd_unused: got %b want %b", fwd, 4'b0000); end
        set_id(0, 2, 3, 0, 1, 0, 0, 0, 0);                 // ID empty
        #1;
        checks++; if (fwd !== 4'b0000) begin errors++; $display("[TB] FAIL fwd_invalid: got %b want %b", fwd, 4'b0000); end
    endtask

    task automatic test_mem_busy();
        drain();
        set_id(1, 1, 0, 1, 0, 6, 1, 1, 0);                 // lw x6
        tick();
        set_id(1, 6, 1, 1, 1, 0, 0, 0, 1);                 // beq x6,x1
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1'b1;
            branch_taken = (i == 1);
            #1;
            checks++; if (ctl !== 4'b1100) begin errors++; $display("[TB] FAIL busy_ctl%0d: got %b want %b", i, ctl, 4'b1100); end
            checks++; if (dut.state !== STALL2) begin errors++; $display("[TB] FAIL busy_state%0d: got %0d want %0d", i, dut.state, STALL2); end
            tick();
        end
        mem_busy = 1'b0;
        branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("[TB] FAIL busy_resume: got %b want %b", ctl, 4'b1110); end
        checks++; if ({dut.mem_valid, dut.mem_rd} !== {1'b1, 5'd6}) begin errors++; $display("[TB] FAIL busy_shadow: got %b want %b", {dut.mem_valid, dut.mem_rd}, {1'b1, 5'd6}); end
        tick();
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL busy_release: got %b want %b", ctl, 4'b0000); end
        checks++; if (dut.state !== STALL1) begin errors++; $display("[TB] FAIL busy_state1: got %0d want %0d", dut.state, STALL1); end
    endtask

    task automatic test_flush();
        drain();
        set_id(1, 1, 2, 1, 1, 0, 0, 0, 1);                 // beq x1,x2, no producers
        branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0001) begin errors++; $display("[TB] FAIL flush_pulse: got %b want %b", ctl, 4'b0001); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL flush_end: got %b want %b", ctl, 4'b0000); end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(1, 1, 0, 1, 0, 6, 1, 1, 0);                 // lw x6
        tick();
        set_id(1, 6, 1, 1, 1, 0, 0, 0, 1);                 // beq x6,x1
        tick();
        tick();
        mem_busy = 1'b1;                                   // keep the pipe frozen in STALL1
        #1;
        checks++; if (dut.state !== STALL1) begin errors++; $display("[TB] FAIL rst_mid_pre: got %0d want %0d", dut.state, STALL1); end
        checks++; if (ctl !== 4'b1100) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want %b", ctl, 4'b1100); end
        rst_n = 1'b0;
        branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_ctl: got %b want %b", ctl, 4'b0000); end
        checks++; if (dut.state !== RUN) begin errors++; $display("[TB] FAIL rst_mid_state: got %0d want %0d", dut.state, RUN); end
        checks++; if ({dut.ex_valid, dut.mem_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_shadow: got %b want %b", {dut.ex_valid, dut.mem_valid}, 2'b00); end
        #2;
        rst_n = 1'b1;
        mem_busy = 1'b0;
        branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL rst_after_ctl: got %b want %b", ctl, 4'b0000); end
        tick();
        #1;
        checks++; if (dut.state !== RUN) begin errors++; $display("[TB] FAIL rst_after_state: got %0d want %0d", dut.state, RUN); end
    endtask

    // Scenario sequence; the watchdog below bounds the whole run
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        branch_taken = 1'b0;
        mem_busy = 1'b0;
        #1;
        test_reset();
        test_alu_branch();
        test_load_branch();
        test_load_use_x0();
        test_fwd_priority();
        test_mem_busy();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
